// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one single-beat memory port between the instruction
//               fetch requester (I) and the data requester (D). One
//               transaction in flight at a time; the granted request is
//               registered, driven to memory, and the response is returned
//               to its owner with addr_ok/data_ok handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int FAIR   = 1,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    // fetch requester
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_data,
    // data requester
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [63:0]       d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [63:0]       d_rdata,
    // memory bus
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [63:0]       m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [63:0]       m_rdata
);

    localparam logic c_fair = (FAIR != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              own_q, own_d;        // 0 = I, 1 = D
    logic              last_d_q, last_d_d;  // owner of the last completed transaction
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [31:0]       i_data_q, i_data_d;
    logic [63:0]       d_rdata_q, d_rdata_d;
    logic              i_data_ok_q, i_data_ok_d;
    logic              d_data_ok_q, d_data_ok_d;

    logic              grant_i;
    logic              grant_d;
    logic              resp_fire;

    // Arbitration: only in IDLE and never while reset is held, so no
    // addr_ok can leak out during reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == S_IDLE && !reset) begin
            if (d_valid && i_valid) begin
                if (c_fair && last_d_q) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (d_valid) begin
                grant_d = 1'b1;
            end else if (i_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    // A response is taken in WAIT, or in REQ when it arrives together with
    // m_ready; any other m_rvalid is ignored.
    assign resp_fire = m_rvalid &&
                       ((state_q == S_WAIT) || (state_q == S_REQ && m_ready));

    // Next-state, request capture and response latching.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        last_d_d    = last_d_q;
        addr_d      = addr_q;
        size_d      = size_q;
        strobe_d    = strobe_q;
        wdata_d     = wdata_q;
        i_data_d    = i_data_q;
        d_rdata_d   = d_rdata_q;
        i_data_ok_d = 1'b0;
        d_data_ok_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    own_d    = 1'b1;
                    addr_d   = d_addr;
                    size_d   = d_size;
                    strobe_d = d_strobe;
                    wdata_d  = d_wdata;
                    state_d  = S_REQ;
                end else if (grant_i) begin
                    own_d    = 1'b0;
                    addr_d   = i_addr;
                    size_d   = 3'd2;
                    strobe_d = 8'h00;
                    wdata_d  = 64'h0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (m_ready) begin
                    state_d = m_rvalid ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_fire) begin
            last_d_d = own_q;
            if (own_q) begin
                d_rdata_d   = m_rdata;
                d_data_ok_d = 1'b1;
            end else begin
                // Instruction word is picked from the 8-byte line by addr[2].
                i_data_d    = addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
                i_data_ok_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            own_q       <= 1'b0;
            last_d_q    <= 1'b0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            strobe_q    <= 8'h00;
            wdata_q     <= 64'h0;
            i_data_q    <= 32'h0;
            d_rdata_q   <= 64'h0;
            i_data_ok_q <= 1'b0;
            d_data_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            last_d_q    <= last_d_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            strobe_q    <= strobe_d;
            wdata_q     <= wdata_d;
            i_data_q    <= i_data_d;
            d_rdata_q   <= d_rdata_d;
            i_data_ok_q <= i_data_ok_d;
            d_data_ok_q <= d_data_ok_d;
        end
    end

    assign i_addr_ok = grant_i;
    assign d_addr_ok = grant_d;
    assign i_data_ok = i_data_ok_q;
    assign d_data_ok = d_data_ok_q;
    assign i_data    = i_data_q;
    assign d_rdata   = d_rdata_q;
    assign m_valid   = (state_q == S_REQ);
    assign m_addr    = addr_q;
    assign m_size    = size_q;
    assign m_strobe  = strobe_q;
    assign m_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed bench for mem_bus_arbiter with a request/response
//               scoreboard; a second instance exercises strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, d_valid, m_ready, m_rvalid;
    logic [63:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_valid;
    logic [31:0] i_data;
    logic [63:0] d_rdata, m_addr, m_wdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;

    // strict-priority instance signals
    logic        s_i_valid, s_d_valid, s_m_ready, s_m_rvalid;
    logic [63:0] s_i_addr, s_d_addr, s_d_wdata, s_m_rdata;
    logic [2:0]  s_d_size;
    logic [7:0]  s_d_strobe;
    logic        s_i_addr_ok, s_i_data_ok, s_d_addr_ok, s_d_data_ok, s_m_valid;
    logic [31:0] s_i_data;
    logic [63:0] s_d_rdata, s_m_addr, s_m_wdata;
    logic [2:0]  s_m_size;
    logic [7:0]  s_m_strobe;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
    } req_t;

    typedef struct packed {
        logic        own;   // 1 = D
        logic        chk;   // compare data
        logic [63:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t mon_r;
    rsp_t mon_p;

    mem_bus_arbiter #(.FAIR(1), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    mem_bus_arbiter #(.FAIR(0), .ADDR_W(64)) dut_sp (
        .clk(clk), .reset(reset),
        .i_valid(s_i_valid), .i_addr(s_i_addr), .i_addr_ok(s_i_addr_ok),
        .i_data_ok(s_i_data_ok), .i_data(s_i_data),
        .d_valid(s_d_valid), .d_addr(s_d_addr), .d_size(s_d_size), .d_strobe(s_d_strobe),
        .d_wdata(s_d_wdata), .d_addr_ok(s_d_addr_ok), .d_data_ok(s_d_data_ok), .d_rdata(s_d_rdata),
        .m_valid(s_m_valid), .m_addr(s_m_addr), .m_size(s_m_size), .m_strobe(s_m_strobe),
        .m_wdata(s_m_wdata), .m_ready(s_m_ready), .m_rvalid(s_m_rvalid), .m_rdata(s_m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT accepts a memory request
    // or presents a response.
    always @(negedge clk) begin
        if (!reset) begin
            check("dual_ok", {62'b0, i_addr_ok & d_addr_ok, i_data_ok & d_data_ok}, 64'h0);
            if (m_valid && m_ready) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected none", m_addr);
                end else begin
                    mon_r = req_q.pop_front();
                    check("req_addr",   m_addr,   mon_r.addr);
                    check("req_size",   {61'b0, m_size},   {61'b0, mon_r.size});
                    check("req_strobe", {56'b0, m_strobe}, {56'b0, mon_r.strobe});
                    check("req_wdata",  m_wdata,  mon_r.wdata);
                end
            end
            if (i_data_ok || d_data_ok) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_ok: got i=%0b d=%0b expected none", i_data_ok, d_data_ok);
                end else begin
                    mon_p = rsp_q.pop_front();
                    check("rsp_owner", {63'b0, d_data_ok}, {63'b0, mon_p.own});
                    if (mon_p.chk) begin
                        check("rsp_data", mon_p.own ? d_rdata : {32'b0, i_data}, mon_p.data);
                    end
                end
            end
        end
    end

    // One complete transaction from IDLE; leaves the DUT idle with inputs low.
    task automatic txn(input bit is_d, input logic [63:0] addr, input logic [2:0] size,
                       input logic [7:0] strb, input logic [63:0] wd, input int rdy_wait,
                       input bit same, input logic [63:0] rdata, input bit chk,
                       input logic [63:0] exp);
        rsp_t p;
        if (is_d) begin
            d_valid = 1'b1; d_addr = addr; d_size = size; d_strobe = strb; d_wdata = wd;
            req_q.push_back('{addr, size, strb, wd});
        end else begin
            i_valid = 1'b1; i_addr = addr;
            req_q.push_back('{addr, 3'd2, 8'h00, 64'h0});
        end
        p = '{is_d, chk, exp};
        @(negedge clk);
        check("addr_ok", {62'b0, i_addr_ok, d_addr_ok}, is_d ? 64'h1 : 64'h2);
        cyc();
        for (int k = 0; k < rdy_wait; k++) begin
            @(negedge clk);
            check("bp_valid", {63'b0, m_valid}, 64'h1);
            check("bp_addr", m_addr, addr);
            check("bp_quiet", {60'b0, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 64'h0);
            cyc();
        end
        m_ready = 1'b1;
        if (same) begin
            m_rvalid = 1'b1; m_rdata = rdata; rsp_q.push_back(p);
        end
        @(negedge clk);
        check("req_valid", {63'b0, m_valid}, 64'h1);
        cyc();
        m_ready = 1'b0;
        if (!same) begin
            m_rvalid = 1'b1; m_rdata = rdata; rsp_q.push_back(p);
            @(negedge clk);
            check("wait_quiet", {61'b0, m_valid, i_data_ok, d_data_ok}, 64'h0);
            cyc();
        end
        m_rvalid = 1'b0;
        i_valid  = 1'b0;
        d_valid  = 1'b0;
        @(negedge clk);
        check("data_ok", {62'b0, i_data_ok, d_data_ok}, is_d ? 64'h1 : 64'h2);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_igr;
        int s_dgr;
        reset = 1'b1;
        i_valid = 0; d_valid = 0; m_ready = 0; m_rvalid = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; d_size = 0; d_strobe = 0;
        s_i_valid = 0; s_d_valid = 0; s_m_ready = 0; s_m_rvalid = 0;
        s_i_addr = 64'h8000_0100; s_d_addr = 64'h8000_0200; s_d_wdata = 0;
        s_m_rdata = 0; s_d_size = 3'd3; s_d_strobe = 0;
        repeat (3) cyc();
        reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_ctl", {48'b0, m_valid, m_size, m_strobe, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 64'h0);
        check("rst_maddr", m_addr, 64'h0);
        check("rst_mwdata", m_wdata, 64'h0);
        check("rst_idata", {32'b0, i_data}, 64'h0);
        check("rst_drdata", d_rdata, 64'h0);
        cyc();

        // I-only, best-case latency; upper word selected by addr[2]
        txn(0, 64'h8000_0004, 3'd0, 8'h00, 64'h0, 0, 0, 64'h0013_0000_0000_0093, 1, 64'h0013_0000);

        // Simultaneous requests with fairness, then same-cycle ready/rvalid read
        i_valid = 1; i_addr = 64'h8000_000C;
        d_valid = 1; d_addr = 64'h8000_1000; d_size = 3'd3; d_strobe = 8'hFF;
        d_wdata = 64'h1122_3344_5566_7788;
        req_q.push_back('{64'h8000_1000, 3'd3, 8'hFF, 64'h1122_3344_5566_7788});
        @(negedge clk);
        check("fair_first_d", {62'b0, i_addr_ok, d_addr_ok}, 64'h1);
        cyc(); m_ready = 1;
        @(negedge clk);
        cyc(); m_ready = 0; m_rvalid = 1; m_rdata = 64'h0;
        rsp_q.push_back('{1'b1, 1'b0, 64'h0});
        @(negedge clk);
        cyc(); m_rvalid = 0;
        req_q.push_back('{64'h8000_000C, 3'd2, 8'h00, 64'h0});
        @(negedge clk);
        check("fair_then_i", {61'b0, i_addr_ok, d_addr_ok, d_data_ok}, 64'h5);
        cyc();
        d_addr = 64'h8000_0010; d_strobe = 8'h00; d_size = 3'd3; d_wdata = 64'h0;
        m_ready = 1; m_rvalid = 1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        rsp_q.push_back('{1'b0, 1'b1, 64'hAAAA_BBBB});
        @(negedge clk);
        cyc();
        m_ready = 0; m_rvalid = 0; i_valid = 0;
        req_q.push_back('{64'h8000_0010, 3'd3, 8'h00, 64'h0});
        @(negedge clk);
        check("alt_back_d", {61'b0, i_data_ok, i_addr_ok, d_addr_ok}, 64'h5);
        cyc();
        m_ready = 1; m_rvalid = 1; m_rdata = 64'hDEAD_BEEF_0000_0001;
        rsp_q.push_back('{1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001});
        @(negedge clk);
        cyc();
        m_ready = 0; m_rvalid = 0; d_valid = 0;
        @(negedge clk);
        check("same_cycle_dok", {63'b0, d_data_ok}, 64'h1);
        cyc();

        // Backpressure: m_ready low for 5 REQ cycles
        txn(1, 64'h8000_2008, 3'd3, 8'h00, 64'h0, 5, 0, 64'h0102_0304_0506_0708, 1, 64'h0102_0304_0506_0708);

        // D write completed with same-cycle response
        txn(1, 64'h8000_3000, 3'd2, 8'h0F, 64'h0000_0000_A5A5_A5A5, 0, 1, 64'h0, 0, 64'h0);

        // Reset in WAIT, late m_rvalid ignored
        i_valid = 1; i_addr = 64'h8000_0040;
        req_q.push_back('{64'h8000_0040, 3'd2, 8'h00, 64'h0});
        @(negedge clk);
        check("rst_t_addr_ok", {63'b0, i_addr_ok}, 64'h1);
        cyc(); m_ready = 1;
        @(negedge clk);
        cyc(); m_ready = 0; reset = 1;
        @(negedge clk);
        cyc(); reset = 0; i_valid = 0; m_rvalid = 1; m_rdata = 64'h9999_8888_7777_6666;
        @(negedge clk);
        check("rst2_ctl", {48'b0, m_valid, m_size, m_strobe, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 64'h0);
        check("rst2_maddr", m_addr, 64'h0);
        check("rst2_mwdata", m_wdata, 64'h0);
        check("rst2_idata", {32'b0, i_data}, 64'h0);
        check("rst2_drdata", d_rdata, 64'h0);
        cyc(); m_rvalid = 0;
        @(negedge clk);
        check("late_rvalid_quiet", {62'b0, i_data_ok, d_data_ok}, 64'h0);
        cyc();

        // Fresh transactions after reset
        txn(0, 64'h8000_0050, 3'd0, 8'h00, 64'h0, 0, 0, 64'hCAFE_F00D_1234_5678, 1, 64'h1234_5678);
        txn(1, 64'h8000_0018, 3'd3, 8'h00, 64'h0, 0, 0, 64'h5555_6666_7777_8888, 1, 64'h5555_6666_7777_8888);

        // Stray m_rvalid in IDLE
        m_rvalid = 1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_quiet", {60'b0, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 64'h0);
            cyc();
        end
        m_rvalid = 0;
        @(negedge clk);
        check("stray_idata", {32'b0, i_data}, 64'h1234_5678);
        check("stray_drdata", d_rdata, 64'h5555_6666_7777_8888);
        cyc();

        // Strict priority: D held continuously, I never granted
        s_igr = 0; s_dgr = 0;
        s_i_valid = 1; s_d_valid = 1; s_m_ready = 1; s_m_rvalid = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_i_addr_ok) s_igr++;
            if (s_d_addr_ok) s_dgr++;
            cyc();
        end
        s_i_valid = 0; s_d_valid = 0; s_m_ready = 0; s_m_rvalid = 0;
        check("sp_i_grants", s_igr, 64'd0);
        check("sp_d_grants", s_dgr, 64'd10);

        repeat (2) cyc();
        check("req_q_empty", req_q.size(), 64'd0);
        check("rsp_q_empty", rsp_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
